// File: rtl/video_addr_gen.sv
`timescale 1ns/1ps
// Camera stream re-timer: one-cycle registered pass-through with {line, parity, column} pixel addressing and timing checks.
// Optional build macro VIDEO_ADDR_TEST_PATTERN_EN adds pattern_sel, which replaces luma with a 64x32 checkerboard.
module video_addr_gen #(
    parameter int unsigned H_ACTIVE  = 702,
    parameter int unsigned V_ACTIVE  = 288,
    parameter int unsigned ERR_CNT_W = 8
) (
`ifdef VIDEO_ADDR_TEST_PATTERN_EN
    input  logic                 pattern_sel,
`endif
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_frame_valid,
    input  logic                 in_line_valid,
    input  logic                 in_data_valid,
    input  logic [7:0]           in_data,
    output logic                 video_frame_valid,
    output logic                 video_line_valid,
    output logic                 video_data_valid,
    output logic [7:0]           video_data_in,
    output logic [19:0]          video_address,
    output logic [9:0]           line_len,
    output logic [8:0]           frame_lines,
    output logic                 frame_done,
    output logic                 geom_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [9:0] H_LEN = 10'(H_ACTIVE);
    localparam logic [8:0] V_LEN = 9'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        FRAME_GAP,
        IN_LINE
    } state_t;

    state_t                 state_q;
    logic                   fv_q;
    logic                   lv_q;
    logic [9:0]             col_q;
    logic                   col_sat_q;
    logic [8:0]             line_q;
    logic                   par_q;
    logic                   vfv_q;
    logic                   vlv_q;
    logic                   vdv_q;
    logic [7:0]             vdata_q;
    logic [19:0]            addr_q;
    logic [9:0]             line_len_q;
    logic [8:0]             frame_lines_q;
    logic                   frame_done_q;
    logic                   geom_err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic                   frame_rise;
    logic                   frame_open;
    logic                   frame_drop;
    logic                   line_rise;
    logic                   line_open;
    logic                   pix_legal;
    logic [9:0]             col_cur;
    logic [8:0]             line_cur;
    logic                   par_cur;
    logic [7:0]             pix_data;

    // Opening a frame and/or line in this same cycle must already address the
    // pixel present on the inputs, so the "current" fields look through the edge.
    always_comb begin
        frame_rise = in_frame_valid && !fv_q;
        frame_open = (state_q == IDLE) && frame_rise;
        frame_drop = (state_q != IDLE) && !in_frame_valid;
        line_rise  = in_line_valid && !lv_q;
        line_open  = in_frame_valid && line_rise &&
                     ((state_q == FRAME_GAP) || frame_open);
        pix_legal  = in_data_valid && in_frame_valid && in_line_valid &&
                     ((state_q == IN_LINE) || line_open);
        col_cur    = line_open  ? '0 : col_q;
        line_cur   = frame_open ? '0 : line_q;
        par_cur    = frame_open ? !par_q : par_q;
        pix_data   = in_data;
`ifdef VIDEO_ADDR_TEST_PATTERN_EN
        if (pattern_sel) begin
            pix_data = (col_cur[5] ^ line_cur[4]) ? 8'hFF : 8'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fv_q          <= 1'b0;
            lv_q          <= 1'b0;
            col_q         <= '0;
            col_sat_q     <= 1'b0;
            line_q        <= '0;
            par_q         <= 1'b0;
            vfv_q         <= 1'b0;
            vlv_q         <= 1'b0;
            vdv_q         <= 1'b0;
            vdata_q       <= '0;
            addr_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            frame_done_q  <= 1'b0;
            geom_err_q    <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            fv_q         <= in_frame_valid;
            lv_q         <= in_line_valid;
            vfv_q        <= in_frame_valid;
            vlv_q        <= in_frame_valid && in_line_valid;
            vdv_q        <= pix_legal;
            vdata_q      <= pix_data;
            frame_done_q <= 1'b0;

            if (line_open) begin
                col_q     <= '0;
                col_sat_q <= 1'b0;
            end

            // The column sticks at all-ones; only pixels beyond that one are errors.
            if (pix_legal) begin
                addr_q <= {line_cur, par_cur, col_cur};
                if (col_cur != '1) begin
                    col_q <= col_cur + 10'd1;
                end else begin
                    col_q     <= col_cur;
                    col_sat_q <= 1'b1;
                    if (col_sat_q && !line_open) begin
                        geom_err_q <= 1'b1;
                    end
                end
            end

            if (in_data_valid && !pix_legal && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (frame_rise) begin
                        line_q  <= '0;
                        par_q   <= !par_q;
                        state_q <= line_open ? IN_LINE : FRAME_GAP;
                    end
                end
                FRAME_GAP: begin
                    if (frame_drop) begin
                        frame_lines_q <= line_q;
                        frame_done_q  <= 1'b1;
                        if (line_q != V_LEN) begin
                            geom_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (line_open) begin
                        state_q <= IN_LINE;
                    end
                end
                IN_LINE: begin
                    if (frame_drop) begin
                        frame_lines_q <= line_q;
                        frame_done_q  <= 1'b1;
                        if (line_q != V_LEN) begin
                            geom_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (!in_line_valid) begin
                        if (col_q != '0) begin
                            line_len_q <= col_q;
                            if (line_q != '1) begin
                                line_q <= line_q + 9'd1;
                            end
                            if (col_q != H_LEN) begin
                                geom_err_q <= 1'b1;
                            end
                        end
                        state_q <= FRAME_GAP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign video_frame_valid = vfv_q;
    assign video_line_valid  = vlv_q;
    assign video_data_valid  = vdv_q;
    assign video_data_in     = vdata_q;
    assign video_address     = addr_q;
    assign line_len          = line_len_q;
    assign frame_lines       = frame_lines_q;
    assign frame_done        = frame_done_q;
    assign geom_err          = geom_err_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: doc/video_addr_gen.md
Name: video_addr_gen

Overview:
Upstream neighbour of the maze-tracking video stage. It takes the raw camera pixel stream (frame/line/data valid strobes plus 8-bit luma) and re-times it by one registered cycle. It attaches a 20-bit pixel address {line, frame parity, column}, which the tracker uses to derive its row and column counters. It also reports per-line and per-frame geometry and flags malformed timing, so a bad camera stream is visible before it corrupts maze detection.

Parameters:
H_ACTIVE, 702, expected pixels per line (columns 0..701)
V_ACTIVE, 288, expected lines per frame (rows 0..287)
ERR_CNT_W, 8, width of the protocol-error counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_frame_valid  in  1  raw frame strobe
in_line_valid  in  1  raw line strobe
in_data_valid  in  1  raw pixel strobe
in_data  in  8  raw luma
video_frame_valid  out  1  registered frame strobe
video_line_valid  out  1  registered line strobe, gated by frame
video_data_valid  out  1  registered pixel strobe, legal pixels only
video_data_in  out  8  registered luma
video_address  out  20  [19:11] line index, [10] frame parity, [9:0] column index
line_len  out  10  pixel count of last completed line
frame_lines  out  9  line count of last completed frame
frame_done  out  1  one-cycle pulse when a frame closes
geom_err  out  1  sticky: a line length != H_ACTIVE, or a line count != V_ACTIVE
err_cnt  out  ERR_CNT_W  count of illegal pixel strobes; saturates at all-ones

Behaviour:
- Reset: synchronous, active-high. While reset is high, every output is 0, all counters are 0, frame parity is 0, and the FSM is in IDLE.
- Latency: exactly one clk from in_* to video_*. The address is aligned with the same-cycle video_data_valid and video_data_in.
- FSM states:
  - IDLE: waiting for in_frame_valid rising.
  - FRAME_GAP: in frame, between lines.
  - IN_LINE: in a line.
- Transitions:
  - IDLE -> FRAME_GAP on in_frame_valid rising. Line index := 0, frame parity toggles.
  - FRAME_GAP -> IN_LINE on in_line_valid rising while in_frame_valid is high. Column := 0.
  - IN_LINE -> FRAME_GAP on in_line_valid falling. If the line had at least 1 pixel: line_len := pixel count, line index += 1 (saturating at 511), and geom_err sets if the count != H_ACTIVE. Zero-pixel lines are ignored.
  - Any state -> IDLE on in_frame_valid falling. frame_lines := completed line count, and frame_done pulses on the following cycle. geom_err sets if the line count != V_ACTIVE.
  - A frame drop during IN_LINE aborts the line without updating line_len. video_line_valid is low on the same output cycle as video_frame_valid.
- Column counter:
  - Increments after each legal pixel, so the first pixel of a line has address column 0.
  - Saturates at 1023. Further pixels reuse address 1023 and set geom_err.
- Legal pixel: in_data_valid high while in IN_LINE with in_line_valid and in_frame_valid high. Illegal strobes produce video_data_valid = 0 and increment err_cnt.
- video_line_valid is forced 0 outside frame; a line strobe without a frame is ignored and not counted.
- Outside a legal pixel, video_address holds its last value. video_data_in always follows in_data.
- Simultaneous frame rise and line rise in one cycle: the line is opened and its first pixel is accepted.
- geom_err and err_cnt clear only on reset.
- Reset mid-line: all state clears immediately. The first full frame after reset starts with frame parity 1.

Optional Feature:
VIDEO_ADDR_TEST_PATTERN_EN
- Defined: adds input port pattern_sel (1 bit). When pattern_sel=1, video_data_in = 8'hFF if column[5] xor line[4] = 1, else 8'h00. This is a 64x32 checkerboard for exercising downstream binarization. Timing and address behaviour are unchanged.
- Undefined: the port is absent and data always passes through.

Test Plan:
- Nominal frame: 288 lines of 702 pixels with 10-cycle line gaps.
  - First pixel: address 0x00400 (parity 1).
  - Last pixel: line 287, column 701.
  - Status: frame_done pulses once, frame_lines=288, line_len=702, geom_err=0, err_cnt=0.
- Short line: line 5 carries 700 pixels -> line_len=700 after that line, geom_err=1, addresses on line 6 start at column 0.
- Illegal strobes: 3 in_data_valid pulses during a line gap plus 2 outside the frame -> video_data_valid stays 0 for those cycles, err_cnt=5.
- Frame drop mid-line at line 100, column 350 -> video_line_valid and video_frame_valid fall together, frame_lines=100, line_len keeps its previous value, geom_err=1.
- Reset mid-line at column 200 -> next cycle all outputs are 0. The next frame starts with parity 1, line 0, column 0.
- With VIDEO_ADDR_TEST_PATTERN_EN and pattern_sel=1:
  - line 0, columns 0..31 -> 0x00.
  - line 0, columns 32..63 -> 0xFF.
  - line 16, column 0 -> 0xFF.
